// File: rtl/seq_squarer.sv
// Iterative shift-add squarer: one partial product per clock, valid/ready on both sides.
// Result appears WIDTH cycles after the operand is accepted and holds until the next result.
module seq_squarer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               busy
);

  localparam int unsigned YW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [YW-1:0]     acc_q, acc_d;
  logic [YW-1:0]     mcand_q, mcand_d;
  logic [YW-1:0]     y_q, y_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [YW-1:0]     acc_sum;

  // Accumulator value after this cycle's partial product; also the final result on the last step.
  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d    = '0;
          mcand_d  = YW'(a);
          mplier_d = a;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          y_d     = acc_sum;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StCalc) || (state_q == StDone);
  assign y         = y_q;

endmodule
